// File: rtl/block_ram_pkg.sv
// Shared constants and types for the dual-port block RAM.
package block_ram_pkg;

    // Same-port read-during-write behaviour.
    localparam int unsigned READ_FIRST  = 0;
    localparam int unsigned WRITE_FIRST = 1;

    // Clear engine states.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/block_ram_dp_core.sv
// Inferred storage array with two synchronous write/read ports.
module block_ram_dp_core
    import block_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned WRITE_MODE = READ_FIRST
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_a,
    input  logic                  re_a,
    input  logic                  fwd_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] din_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic                  we_b,
    input  logic                  re_b,
    input  logic                  fwd_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] din_b,
    output logic [DATA_WIDTH-1:0] q_b
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Array writes; port A is applied last so it would win an overlap.
    always_ff @(posedge clk) begin
        if (we_b) mem[addr_b] <= din_b;
        if (we_a) mem[addr_a] <= din_a;
    end

    // Read registers; fwd selects the port's own write data in WRITE_FIRST
    // mode, otherwise the pre-write array word is returned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            if (re_a) q_a <= (WRITE_MODE == WRITE_FIRST && fwd_a) ? din_a : mem[addr_a];
            if (re_b) q_b <= (WRITE_MODE == WRITE_FIRST && fwd_b) ? din_b : mem[addr_b];
        end
    end

endmodule

// File: rtl/block_ram_dp.sv
// Parametrised true dual-port RAM with clear engine and optional output stage.
module block_ram_dp
    import block_ram_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 16,
    parameter int unsigned           ADDR_WIDTH  = 10,
    parameter int unsigned           OUT_REG     = 0,
    parameter int unsigned           WRITE_MODE  = READ_FIRST,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_req,
    output logic                  busy,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta,
    output logic                  valida,
    input  logic                  enb,
    input  logic                  web,
    input  logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] dinb,
    output logic [DATA_WIDTH-1:0] doutb,
    output logic                  validb
);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] clr_addr_q;
    logic                  busy_q;

    logic                  acc_a, acc_b;
    logic                  core_we_a, core_we_b;
    logic [ADDR_WIDTH-1:0] core_addr_a;
    logic [DATA_WIDTH-1:0] core_din_a;
    logic [DATA_WIDTH-1:0] core_q_a, core_q_b;
    logic                  v1_a_q, v1_b_q;

    // Clear FSM: walks every address once, busy registered alongside state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            busy_q     <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (clear_req) begin
                        state_q    <= CLEAR;
                        clr_addr_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                CLEAR: begin
                    clr_addr_q <= clr_addr_q + ADDR_WIDTH'(1);
                    if (&clr_addr_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign acc_a = ena & ~busy_q;
    assign acc_b = enb & ~busy_q;

    // Port A write mux (clear engine owns port A while busy) and A-wins gating of B.
    always_comb begin
        core_we_a   = acc_a & wea;
        core_addr_a = addra;
        core_din_a  = dina;
        if (busy_q) begin
            core_we_a   = 1'b1;
            core_addr_a = clr_addr_q;
            core_din_a  = CLEAR_VALUE;
        end
        core_we_b = acc_b & web & ~(acc_a & wea & (addra == addrb));
    end

    block_ram_dp_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .WRITE_MODE (WRITE_MODE)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .we_a   (core_we_a),
        .re_a   (acc_a),
        .fwd_a  (acc_a & wea),
        .addr_a (core_addr_a),
        .din_a  (core_din_a),
        .q_a    (core_q_a),
        .we_b   (core_we_b),
        .re_b   (acc_b),
        .fwd_b  (acc_b & web),
        .addr_b (addrb),
        .din_b  (dinb),
        .q_b    (core_q_b)
    );

    // First valid stage, aligned with the core read registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_a_q <= 1'b0;
            v1_b_q <= 1'b0;
        end else begin
            v1_a_q <= acc_a;
            v1_b_q <= acc_b;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] d2_a_q, d2_b_q;
        logic                  v2_a_q, v2_b_q;

        // Output stage captures only completing reads so dout holds otherwise.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                d2_a_q <= '0;
                d2_b_q <= '0;
                v2_a_q <= 1'b0;
                v2_b_q <= 1'b0;
            end else begin
                v2_a_q <= v1_a_q;
                v2_b_q <= v1_b_q;
                if (v1_a_q) d2_a_q <= core_q_a;
                if (v1_b_q) d2_b_q <= core_q_b;
            end
        end

        assign douta  = d2_a_q;
        assign doutb  = d2_b_q;
        assign valida = v2_a_q;
        assign validb = v2_b_q;
    end else begin : g_no_out_reg
        assign douta  = core_q_a;
        assign doutb  = core_q_b;
        assign valida = v1_a_q;
        assign validb = v1_b_q;
    end

endmodule

// File: tb/tb_block_ram_dp.sv
// Directed bench for block_ram_dp: dut0 = OUT_REG 0 / READ_FIRST / clear 0000,
// dut1 = OUT_REG 1 / WRITE_FIRST / clear DEAD. Inputs change and outputs are
// sampled on the falling edge.
module tb_block_ram_dp;

    logic        clk;
    logic        reset     [2];
    logic        clear_req [2];
    logic        busy      [2];
    logic        ena       [2];
    logic        wea       [2];
    logic [3:0]  addra     [2];
    logic [15:0] dina      [2];
    logic [15:0] douta     [2];
    logic        valida    [2];
    logic        enb       [2];
    logic        web       [2];
    logic [3:0]  addrb     [2];
    logic [15:0] dinb      [2];
    logic [15:0] doutb     [2];
    logic        validb    [2];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    block_ram_dp #(
        .DATA_WIDTH (16), .ADDR_WIDTH (4), .OUT_REG (0), .WRITE_MODE (0),
        .CLEAR_VALUE (16'h0000)
    ) dut0 (
        .clk (clk), .reset (reset[0]), .clear_req (clear_req[0]), .busy (busy[0]),
        .ena (ena[0]), .wea (wea[0]), .addra (addra[0]), .dina (dina[0]),
        .douta (douta[0]), .valida (valida[0]),
        .enb (enb[0]), .web (web[0]), .addrb (addrb[0]), .dinb (dinb[0]),
        .doutb (doutb[0]), .validb (validb[0])
    );

    block_ram_dp #(
        .DATA_WIDTH (16), .ADDR_WIDTH (4), .OUT_REG (1), .WRITE_MODE (1),
        .CLEAR_VALUE (16'hDEAD)
    ) dut1 (
        .clk (clk), .reset (reset[1]), .clear_req (clear_req[1]), .busy (busy[1]),
        .ena (ena[1]), .wea (wea[1]), .addra (addra[1]), .dina (dina[1]),
        .douta (douta[1]), .valida (valida[1]),
        .enb (enb[1]), .web (web[1]), .addrb (addrb[1]), .dinb (dinb[1]),
        .doutb (doutb[1]), .validb (validb[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic logic [15:0] cv_of(input int d);
        return (d == 0) ? 16'h0000 : 16'hDEAD;
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (dut%0d): observed %0h expected %0h", tag, d, obs, exp);
        end
    endtask

    task automatic idle(input int d);
        clear_req[d] = 1'b0;
        ena[d] = 1'b0; wea[d] = 1'b0; addra[d] = '0; dina[d] = '0;
        enb[d] = 1'b0; web[d] = 1'b0; addrb[d] = '0; dinb[d] = '0;
    endtask

    // One-cycle request on either/both ports.
    task automatic drive(input int d,
                         input logic ea, input logic wa, input logic [3:0] aa,
                         input logic [15:0] da,
                         input logic eb, input logic wb, input logic [3:0] ab,
                         input logic [15:0] db);
        ena[d] = ea; wea[d] = wa; addra[d] = aa; dina[d] = da;
        enb[d] = eb; web[d] = wb; addrb[d] = ab; dinb[d] = db;
        @(negedge clk);
        idle(d);
    endtask

    // Waits (bounded) for the port's valid; lat counts cycles from acceptance.
    task automatic wait_valid(input int d, input int p, output int lat);
        lat = 1;
        while (!((p == 0) ? valida[d] : validb[d]) && lat < 6) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic rd(input int d, input int p, input logic [3:0] addr,
                      input logic [15:0] exp, input string tag);
        int lat;
        if (p == 0) drive(d, 1'b1, 1'b0, addr, 16'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        else        drive(d, 1'b0, 1'b0, 4'h0, 16'h0, 1'b1, 1'b0, addr, 16'h0);
        wait_valid(d, p, lat);
        chk({tag, "_lat"}, d, 32'(lat), 32'(lat_of(d)));
        chk({tag, "_data"}, d, 32'((p == 0) ? douta[d] : doutb[d]), 32'(exp));
        @(negedge clk);
        chk({tag, "_pulse"}, d, 32'((p == 0) ? valida[d] : validb[d]), 32'(0));
    endtask

    // Releases reset and checks busy stays high for exactly 16 cycles.
    task automatic release_and_count(input int d, input string tag);
        int cnt;
        reset[d] = 1'b0;
        cnt = 0;
        while (busy[d] && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        chk(tag, d, 32'(cnt), 32'(16));
    endtask

    initial begin
        int lat;
        int extra;
        int n;
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1;
            idle(d);
        end
        repeat (3) @(negedge clk);

        for (int d = 0; d < 2; d++) begin
            // Reset state.
            chk("rst_douta", d, 32'(douta[d]), 32'(0));
            chk("rst_doutb", d, 32'(doutb[d]), 32'(0));
            chk("rst_valida", d, 32'(valida[d]), 32'(0));
            chk("rst_validb", d, 32'(validb[d]), 32'(0));
            chk("rst_busy", d, 32'(busy[d]), 32'(1));
            release_and_count(d, "busy_cycles");

            // Every location holds the clear value, alternating ports.
            for (int a = 0; a < 16; a++) rd(d, a % 2, 4'(a), cv_of(d), "clr_read");

            // Write on A, read back on B the next cycle.
            drive(d, 1'b1, 1'b1, 4'd3, 16'h1234, 1'b0, 1'b0, 4'h0, 16'h0);
            rd(d, 1, 4'd3, 16'h1234, "xport_rd");

            // Same-port read-during-write plus cross-port read of the same word.
            drive(d, 1'b1, 1'b1, 4'd5, 16'hAAAA, 1'b0, 1'b0, 4'h0, 16'h0);
            repeat (3) @(negedge clk);
            drive(d, 1'b1, 1'b1, 4'd5, 16'h5555, 1'b1, 1'b0, 4'd5, 16'h0);
            wait_valid(d, 0, lat);
            chk("rdw_lat", d, 32'(lat), 32'(lat_of(d)));
            chk("rdw_douta", d, 32'(douta[d]), 32'((d == 1) ? 16'h5555 : 16'hAAAA));
            chk("rdw_validb", d, 32'(validb[d]), 32'(1));
            chk("rdw_doutb", d, 32'(doutb[d]), 32'(16'hAAAA));
            @(negedge clk);
            rd(d, 0, 4'd5, 16'h5555, "rdw_stored");

            // Both ports write @7: A's data is stored.
            drive(d, 1'b1, 1'b1, 4'd7, 16'h1111, 1'b1, 1'b1, 4'd7, 16'h2222);
            wait_valid(d, 0, lat);
            chk("ww_douta", d, 32'(douta[d]), 32'((d == 1) ? 16'h1111 : cv_of(d)));
            chk("ww_doutb", d, 32'(doutb[d]), 32'((d == 1) ? 16'h2222 : cv_of(d)));
            @(negedge clk);
            rd(d, 1, 4'd7, 16'h1111, "ww_stored");

            // Clear request alongside a read: the read still completes.
            clear_req[d] = 1'b1; ena[d] = 1'b1; addra[d] = 4'd3;
            @(negedge clk);
            idle(d);
            chk("clr_busy", d, 32'(busy[d]), 32'(1));
            wait_valid(d, 0, lat);
            chk("pend_lat", d, 32'(lat), 32'(lat_of(d)));
            chk("pend_data", d, 32'(douta[d]), 32'(16'h1234));
            @(negedge clk);
            // Requests while busy: no write, no valid.
            drive(d, 1'b1, 1'b1, 4'd3, 16'hFFFF, 1'b1, 1'b1, 4'd0, 16'hFFFF);
            extra = 0;
            n = 0;
            while (busy[d] && n < 40) begin
                if (valida[d] || validb[d]) extra++;
                @(negedge clk);
                n++;
            end
            chk("busy_valids", d, 32'(extra), 32'(0));
            chk("busy_end", d, 32'(busy[d]), 32'(0));
            chk("busy_hold", d, 32'(douta[d]), 32'(16'h1234));
            rd(d, 0, 4'd3, cv_of(d), "post_clr3");
            rd(d, 1, 4'd0, cv_of(d), "post_clr0");

            // Reset five cycles into a clear restarts it.
            drive(d, 1'b1, 1'b1, 4'd2, 16'hBEEF, 1'b0, 1'b0, 4'h0, 16'h0);
            repeat (3) @(negedge clk);
            clear_req[d] = 1'b1;
            @(negedge clk);
            idle(d);
            repeat (5) @(negedge clk);
            reset[d] = 1'b1;
            #1;
            chk("midrst_busy", d, 32'(busy[d]), 32'(1));
            chk("midrst_douta", d, 32'(douta[d]), 32'(0));
            chk("midrst_valida", d, 32'(valida[d]), 32'(0));
            @(negedge clk);
            @(negedge clk);
            release_and_count(d, "rst_busy_cycles");
            for (int a = 0; a < 16; a++) rd(d, 1 - (a % 2), 4'(a), cv_of(d), "rst_clr_read");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
